// File: rtl/ad56x3_spi_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ad56x3_spi_serializer
// Purpose  : Avalon-ST sink that turns each accepted (channel, sample) word
//            into one 24-bit AD5663/AD5643/AD5623 "write and update DAC n"
//            frame and shifts it out MSB first on SYNC_n / SCLK / DIN.
// Revision : 1.0 - initial release
// ============================================================================
module ad56x3_spi_serializer #(
    parameter string SIGN_A     = "UNSIGNED",
    parameter string SIGN_B     = "UNSIGNED",
    parameter int    DATA_WIDTH = 14,
    parameter int    CLK_DIV    = 2,
    parameter int    SYNC_HIGH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  asiValid,
    input  logic                  asiChannel,
    input  logic [DATA_WIDTH-1:0] asiData,
    output logic                  asiRdy,
    output logic                  dacSyncN,
    output logic                  dacSclk,
    output logic                  dacDin,
    output logic                  frameDone
);

    // Counter widths never drop to zero, even for CLK_DIV / SYNC_HIGH of 1.
    localparam int              c_HW         = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
    localparam int              c_GW         = (SYNC_HIGH > 1) ? $clog2(SYNC_HIGH) : 1;
    localparam logic [c_HW-1:0] c_HALF_LAST  = c_HW'(CLK_DIV - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST   = c_GW'(SYNC_HIGH - 1);
    localparam logic [4:0]      c_BIT_LAST   = 5'd23;
    localparam int              c_PAD        = 16 - DATA_WIDTH;
    localparam bit              c_SIGNED_A   = (SIGN_A == "SIGNED");
    localparam bit              c_SIGNED_B   = (SIGN_B == "SIGNED");
    // "Write to and update DAC n" command, placed at frame bits [21:19].
    localparam logic [2:0]      c_CMD_WR_UPD = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [23:0]     r_shift;   // bits still to be sent, next one at [23]
    logic [c_HW-1:0] r_half;    // position inside the current SCLK half-period
    logic [4:0]      r_bit;     // index of the bit currently on DIN (0 = frame MSB)
    logic [c_GW-1:0] r_gap;     // cycles already spent with SYNC_n high

    logic                  w_signed;
    logic [DATA_WIDTH-1:0] w_conv;
    logic [15:0]           w_sample;
    logic [23:0]           w_frame;

    // Build the frame for the word on the sink; offset-binary conversion is a
    // MSB flip chosen by the channel's own sign setting, then left-justified.
    always_comb begin
        w_signed = asiChannel ? c_SIGNED_B : c_SIGNED_A;
        w_conv   = asiData;
        if (w_signed) begin
            w_conv[DATA_WIDTH-1] = ~asiData[DATA_WIDTH-1];
        end
        w_sample = 16'(w_conv) << c_PAD;
        w_frame  = {2'b00, c_CMD_WR_UPD, 2'b00, asiChannel, w_sample};
    end

    // Control FSM with registered pins: accept a word in IDLE, shift 24 bits
    // (DIN only moves together with the SCLK rising edge), then hold SYNC_n
    // high for the inter-frame gap before accepting the next word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            asiRdy    <= 1'b0;
            dacSyncN  <= 1'b1;
            dacSclk   <= 1'b1;
            dacDin    <= 1'b0;
            frameDone <= 1'b0;
            r_shift   <= '0;
            r_half    <= '0;
            r_bit     <= '0;
            r_gap     <= '0;
        end else begin
            frameDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (asiValid && asiRdy) begin
                        // Frame is captured here; later input changes cannot reach it.
                        r_state  <= ST_SHIFT;
                        asiRdy   <= 1'b0;
                        dacSyncN <= 1'b0;
                        dacSclk  <= 1'b1;
                        dacDin   <= w_frame[23];
                        r_shift  <= {w_frame[22:0], 1'b0};
                        r_half   <= '0;
                        r_bit    <= '0;
                        r_gap    <= '0;
                    end else begin
                        asiRdy   <= 1'b1;
                        dacSyncN <= 1'b1;
                        dacSclk  <= 1'b1;
                        dacDin   <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (r_half == c_HALF_LAST) begin
                        r_half <= '0;
                        if (dacSclk) begin
                            // End of the high half: falling edge, DAC samples DIN.
                            dacSclk <= 1'b0;
                        end else if (r_bit == c_BIT_LAST) begin
                            r_state   <= ST_GAP;
                            dacSyncN  <= 1'b1;
                            dacSclk   <= 1'b1;
                            dacDin    <= 1'b0;
                            frameDone <= 1'b1;
                            r_gap     <= '0;
                        end else begin
                            // End of the low half: next bit launches with SCLK rising.
                            r_bit   <= r_bit + 5'd1;
                            dacSclk <= 1'b1;
                            dacDin  <= r_shift[23];
                            r_shift <= {r_shift[22:0], 1'b0};
                        end
                    end else begin
                        r_half <= r_half + c_HW'(1);
                    end
                end

                ST_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= ST_IDLE;
                        asiRdy  <= 1'b1;
                    end else begin
                        r_gap <= r_gap + c_GW'(1);
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    asiRdy   <= 1'b0;
                    dacSyncN <= 1'b1;
                    dacSclk  <= 1'b1;
                    dacDin   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ad56x3_spi_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ad56x3_spi_serializer
// Purpose  : Self-checking bench for ad56x3_spi_serializer. Three instances:
//            0 = DW14/CLK_DIV2/SYNC_HIGH2 unsigned, 1 = same with channel B
//            signed, 2 = DW16/CLK_DIV1/SYNC_HIGH1. A cycle-level expectation
//            derived from frame arithmetic is compared on every cycle, and a
//            pin monitor rebuilds frames for literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad56x3_spi_serializer;

    localparam int N = 3;

    typedef struct packed {
        logic rdy;
        logic sync;
        logic sclk;
        logic din;
        logic fd;
    } outs_t;

    localparam outs_t c_RST  = '{rdy:1'b0, sync:1'b1, sclk:1'b1, din:1'b0, fd:1'b0};
    localparam outs_t c_IDLE = '{rdy:1'b1, sync:1'b1, sclk:1'b1, din:1'b0, fd:1'b0};

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        valid  [N];
    logic        ch     [N];
    logic [15:0] data   [N];
    logic        rdy    [N];
    logic        sync_n [N];
    logic        sclk   [N];
    logic        din    [N];
    logic        fd     [N];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ad56x3_spi_serializer #(.SIGN_A("UNSIGNED"), .SIGN_B("UNSIGNED"), .DATA_WIDTH(14),
                            .CLK_DIV(2), .SYNC_HIGH(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .asiValid(valid[0]), .asiChannel(ch[0]),
        .asiData(data[0][13:0]), .asiRdy(rdy[0]), .dacSyncN(sync_n[0]),
        .dacSclk(sclk[0]), .dacDin(din[0]), .frameDone(fd[0]));

    ad56x3_spi_serializer #(.SIGN_A("UNSIGNED"), .SIGN_B("SIGNED"), .DATA_WIDTH(14),
                            .CLK_DIV(2), .SYNC_HIGH(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .asiValid(valid[1]), .asiChannel(ch[1]),
        .asiData(data[1][13:0]), .asiRdy(rdy[1]), .dacSyncN(sync_n[1]),
        .dacSclk(sclk[1]), .dacDin(din[1]), .frameDone(fd[1]));

    ad56x3_spi_serializer #(.SIGN_A("UNSIGNED"), .SIGN_B("UNSIGNED"), .DATA_WIDTH(16),
                            .CLK_DIV(1), .SYNC_HIGH(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .asiValid(valid[2]), .asiChannel(ch[2]),
        .asiData(data[2]), .asiRdy(rdy[2]), .dacSyncN(sync_n[2]),
        .dacSclk(sclk[2]), .dacDin(din[2]), .frameDone(fd[2]));

    // ---------------- instance configuration ----------------
    function automatic int cd_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction
    function automatic int sh_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction
    function automatic int dw_of(input int i);
        return (i == 2) ? 16 : 14;
    endfunction

    // Frame from the word: command 011, channel, left-justified offset-binary sample.
    function automatic logic [23:0] model_frame(input int i, input logic c, input logic [15:0] d);
        int dw;
        int v;
        dw = dw_of(i);
        v  = int'(d) & ((1 << dw) - 1);
        if (i == 1 && c) v = v ^ (1 << (dw - 1));
        v = (v << (16 - dw)) & 32'hFFFF;
        return 24'((3 << 19) | (int'(c) << 16) | v);
    endfunction

    // Pin values d cycles after the accepting edge.
    function automatic outs_t expect_at(input int d, input logic [23:0] f, input int cd, input int sh);
        outs_t o;
        o = c_IDLE;
        if (d >= 1 && d <= 48 * cd) begin
            o.rdy  = 1'b0;
            o.sync = 1'b0;
            o.sclk = (((d - 1) % (2 * cd)) < cd);
            o.din  = f[23 - ((d - 1) / (2 * cd))];
        end else if (d > 48 * cd && d <= 48 * cd + sh) begin
            o.rdy = 1'b0;
            o.fd  = (d == 48 * cd + 1);
        end
        return o;
    endfunction

    // ---------------- reference model ----------------
    outs_t       cur  [N];
    logic        busy [N];
    int          t0   [N];
    logic [23:0] fr   [N];
    int          cyc = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                cur[i]  = c_RST;
                busy[i] = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < N; i++) begin
                int d;
                if (!busy[i] && cur[i].rdy && valid[i]) begin
                    busy[i] = 1'b1;
                    t0[i]   = cyc;
                    fr[i]   = model_frame(i, ch[i], data[i]);
                end
                if (busy[i]) begin
                    d      = cyc + 1 - t0[i];
                    cur[i] = expect_at(d, fr[i], cd_of(i), sh_of(i));
                    if (d > 48 * cd_of(i) + sh_of(i)) busy[i] = 1'b0;
                end else begin
                    cur[i] = c_IDLE;
                end
            end
        end
    end

    // ---------------- per-cycle compare and pin monitor ----------------
    logic        p_sync [N];
    logic        p_sclk [N];
    logic        p_rdy  [N];
    logic        active [N];
    logic [23:0] shreg  [N];
    int          falls  [N];
    int          lowcnt [N];
    int          fall_e [N];
    int          rise_e [N];
    int          fdcnt  [N] = '{0, 0, 0};

    logic [23:0] capq[$];
    int          lowq[$];
    int          fallsq[$];
    int          fdq[$];
    int          rdyq[$];
    int          fallcyc[$];
    int          highq[$];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            outs_t a;
            a = '{rdy:rdy[i], sync:sync_n[i], sclk:sclk[i], din:din[i], fd:fd[i]};
            tests++;
            if (a !== cur[i]) begin
                failed++;
                $display("FAIL pins_dut%0d cyc %0d: rdy/sync/sclk/din/fd got %b, required %b",
                         i, cyc, a, cur[i]);
            end

            if (!reset_n) begin
                p_sync[i] = 1'b1;
                p_sclk[i] = 1'b1;
                p_rdy[i]  = 1'b0;
                active[i] = 1'b0;
                shreg[i]  = '0;
                falls[i]  = 0;
                lowcnt[i] = 0;
                fall_e[i] = 0;
                rise_e[i] = -1;
            end else begin
                if (p_sync[i] && !sync_n[i]) begin
                    active[i] = 1'b1;
                    fall_e[i] = cyc;
                    falls[i]  = 0;
                    lowcnt[i] = 0;
                    shreg[i]  = '0;
                    highq.push_back((rise_e[i] >= 0) ? (cyc - rise_e[i]) : -1);
                    fallcyc.push_back(cyc);
                end
                if (!sync_n[i]) begin
                    lowcnt[i]++;
                    if (p_sclk[i] && !sclk[i]) begin
                        shreg[i] = {shreg[i][22:0], din[i]};
                        falls[i]++;
                    end
                end
                if (!p_sync[i] && sync_n[i] && active[i]) begin
                    capq.push_back(shreg[i]);
                    lowq.push_back(lowcnt[i]);
                    fallsq.push_back(falls[i]);
                    rise_e[i] = cyc;
                end
                if (fd[i] === 1'b1) begin
                    fdcnt[i]++;
                    if (active[i]) fdq.push_back(cyc - fall_e[i]);
                end
                if (!p_rdy[i] && rdy[i] && active[i]) begin
                    rdyq.push_back(cyc - fall_e[i]);
                    active[i] = 1'b0;
                end
                p_sync[i] = sync_n[i];
                p_sclk[i] = sclk[i];
                p_rdy[i]  = rdy[i];
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        capq.delete();
        lowq.delete();
        fallsq.delete();
        fdq.delete();
        rdyq.delete();
        fallcyc.delete();
        highq.delete();
    endtask

    // Present a word and hold it until accepted; valid stays high afterwards.
    task automatic send(input int i, input logic c, input logic [15:0] d);
        int n;
        @(negedge clk);
        valid[i] = 1'b1;
        ch[i]    = c;
        data[i]  = d;
        n = 0;
        while (rdy[i] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (rdy[i] !== 1'b1) begin
            chk($sformatf("send_timeout_dut%0d", i), 32'(rdy[i]), 32'd1);
            valid[i] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drop(input int i);
        @(negedge clk);
        valid[i] = 1'b0;
        ch[i]    = 1'($urandom_range(0, 1));
        data[i]  = 16'($urandom);
    endtask

    task automatic wait_done(input int nframes);
        int n;
        n = 0;
        while (!(capq.size() >= nframes && (rdy[0] & rdy[1] & rdy[2]) === 1'b1)
               && n < 500 * nframes) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("frames_completed", 32'(capq.size()), 32'(nframes));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach its end, required completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int          fd_before;
        int          n;
        int          i;
        int          last;
        logic        c;
        logic [15:0] d;

        for (int k = 0; k < N; k++) begin
            valid[k] = 1'b0;
            ch[k]    = 1'b0;
            data[k]  = '0;
        end
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("reset_rdy%0d", k),  32'(rdy[k]),    32'd0);
            chk($sformatf("reset_sync%0d", k), 32'(sync_n[k]), 32'd1);
            chk($sformatf("reset_sclk%0d", k), 32'(sclk[k]),   32'd1);
            chk($sformatf("reset_din%0d", k),  32'(din[k]),    32'd0);
            chk($sformatf("reset_fd%0d", k),   32'(fd[k]),     32'd0);
        end
        #1 reset_n = 1'b1;
        @(negedge clk);
        #1;
        for (int k = 0; k < N; k++) chk($sformatf("rdy_first_edge%0d", k), 32'(rdy[k]), 32'd1);

        // Single full-scale word, channel A, unsigned.
        clear_mon();
        send(0, 1'b0, 16'h3FFF);
        drop(0);
        wait_done(1);
        chk("t1_frame",       32'(capq[0]),   32'h18FFFC);
        chk("t1_sync_low",    32'(lowq[0]),   32'd96);
        chk("t1_sclk_falls",  32'(fallsq[0]), 32'd24);
        chk("t1_fd_offset",   32'(fdq[0]),    32'd96);
        chk("t1_rdy_offset",  32'(rdyq[0]),   32'd98);

        // Sign conversion is per channel.
        clear_mon();
        send(1, 1'b1, 16'h2000);
        send(1, 1'b1, 16'h1FFF);
        send(1, 1'b0, 16'h2000);
        drop(1);
        wait_done(3);
        chk("signed_b_2000",   32'(capq[0]), 32'h190000);
        chk("signed_b_1fff",   32'(capq[1]), 32'h19FFFC);
        chk("unsigned_a_2000", 32'(capq[2]), 32'h188000);

        // Back-to-back words with valid held high.
        clear_mon();
        send(0, 1'b0, 16'h0001);
        send(0, 1'b1, 16'h0002);
        send(0, 1'b0, 16'h0003);
        drop(0);
        wait_done(3);
        chk("b2b_frame0",  32'(capq[0]), 32'h180004);
        chk("b2b_frame1",  32'(capq[1]), 32'h190008);
        chk("b2b_frame2",  32'(capq[2]), 32'h18000C);
        chk("b2b_period1", 32'(fallcyc[1] - fallcyc[0]), 32'd99);
        chk("b2b_period2", 32'(fallcyc[2] - fallcyc[1]), 32'd99);
        // High time = SYNC_HIGH gap cycles plus the single IDLE handshake cycle.
        chk("b2b_sync_high1", 32'(highq[1]), 32'd3);
        chk("b2b_sync_high2", 32'(highq[2]), 32'd3);

        // Fastest configuration.
        clear_mon();
        send(2, 1'b0, 16'hA5A5);
        drop(2);
        wait_done(1);
        chk("fast_frame",      32'(capq[0]),   32'h18A5A5);
        chk("fast_sync_low",   32'(lowq[0]),   32'd48);
        chk("fast_sclk_falls", 32'(fallsq[0]), 32'd24);
        chk("fast_fd_offset",  32'(fdq[0]),    32'd48);
        chk("fast_rdy_offset", 32'(rdyq[0]),   32'd49);

        // Reset while bit 10 is on the wire.
        clear_mon();
        fd_before = fdcnt[0];
        send(0, 1'b0, 16'($urandom));
        drop(0);
        n = 0;
        while (!(falls[0] == 10 && sclk[0] === 1'b1 && sync_n[0] === 1'b0) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("midrst_reached_bit10", 32'(falls[0]), 32'd10);
        reset_n = 1'b0;
        #1;
        chk("midrst_sync", 32'(sync_n[0]), 32'd1);
        chk("midrst_sclk", 32'(sclk[0]),   32'd1);
        chk("midrst_din",  32'(din[0]),    32'd0);
        chk("midrst_rdy",  32'(rdy[0]),    32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_rdy_first_edge", 32'(rdy[0]),     32'd1);
        chk("midrst_no_frame_done",  32'(fdcnt[0]),   32'(fd_before));
        chk("midrst_no_partial",     32'(capq.size()), 32'd0);
        send(0, 1'b0, 16'h1234);
        drop(0);
        wait_done(1);
        chk("midrst_next_frame", 32'(capq[0]),   32'h1848D0);
        chk("midrst_next_falls", 32'(fallsq[0]), 32'd24);

        // Randomized traffic across all instances; the per-cycle compare checks it.
        last = 0;
        repeat (45) begin
            i = $urandom_range(0, N - 1);
            c = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if (i != last && valid[last]) drop(last);
            send(i, c, d);
            last = i;
            if ($urandom_range(0, 2) != 0) begin
                drop(i);
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    data[i] = 16'($urandom);
                    ch[i]   = 1'($urandom_range(0, 1));
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (valid[k]) drop(k);
        end
        repeat (150) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
